ram_arbiter: RTL and testbench

- Two-requester round-robin arbiter that shares one single-port synchronous RAM (WIDTH x 2^ADDR_WIDTH; ports rst, clk, we, din, addr, dout; 1-cycle registered read) between requester 0 and requester 1.
- Owns the RAM's we/din/addr, issues at most one access per cycle, and returns read data to the winning requester with a valid strobe.
- Sits between two bus masters (e.g. DMA and CPU-side loader) and the RAM instance.

---
 rtl/ram_arbiter.sv | 112 +++++++++++
 tb/tb_ram_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter in front of one single-port synchronous RAM
// with a 1-cycle registered read.
// At most one RAM access is issued per cycle. The winner gets a one-cycle grant,
// and read data comes back with a one-cycle valid strobe.
// The build-time option RAM_ARB_FIXED_PRIO_EN selects fixed priority, where
// requester 0 wins ties. With it undefined (the default), ties go round-robin.
module ram_arbiter #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0]      wdata0,
  output logic                  gnt0,
  output logic [WIDTH-1:0]      rdata0,
  output logic                  rvalid0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0]      wdata1,
  output logic                  gnt1,
  output logic [WIDTH-1:0]      rdata1,
  output logic                  rvalid1,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_din,
  input  logic [WIDTH-1:0]      ram_dout
);

  logic elig0_p0, elig1_p0;
  logic win0_p0, win1_p0;
  logic rd_pend;
  logic rd_id;

`ifndef RAM_ARB_FIXED_PRIO_EN
  logic rr_ptr;
`endif

  // ---- stage p0: eligibility and winner selection ----
  // Selects the winner. A requester whose grant is currently visible is not
  // eligible, so it can take the next request on the edge that ends its grant.
  always_comb begin
    elig0_p0 = req0 & ~gnt0;
    elig1_p0 = req1 & ~gnt1;
`ifdef RAM_ARB_FIXED_PRIO_EN
    win0_p0  = elig0_p0;
`else
    win0_p0  = elig0_p0 & (~elig1_p0 | ~rr_ptr);
`endif
    win1_p0  = elig1_p0 & ~win0_p0;
  end

`ifndef RAM_ARB_FIXED_PRIO_EN
  // Points at the other requester after every win, including uncontested wins.
  always_ff @(posedge clk) begin
    if (rst)          rr_ptr <= 1'b0;
    else if (win0_p0) rr_ptr <= 1'b1;
    else if (win1_p0) rr_ptr <= 1'b0;
  end
`endif

  // ---- stage p1: registered grant and RAM command ----
  // Issues the winner's command to the RAM and remembers whether a read is in flight.
  // When nobody wins, the address and data hold their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      rd_pend  <= 1'b0;
      rd_id    <= 1'b0;
    end else begin
      gnt0    <= win0_p0;
      gnt1    <= win1_p0;
      rd_pend <= (win0_p0 & ~we0) | (win1_p0 & ~we1);
      rd_id   <= win1_p0;
      if (win0_p0) begin
        ram_we   <= we0;
        ram_addr <= addr0;
        ram_din  <= wdata0;
      end else if (win1_p0) begin
        ram_we   <= we1;
        ram_addr <= addr1;
        ram_din  <= wdata1;
      end else begin
        ram_we   <= 1'b0;
      end
    end
  end

  // ---- stage p2: read-data valid, aligned with the RAM's registered dout ----
  // Turns a pending read into a valid strobe for the requester that issued it.
  // A reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= rd_pend & ~rd_id;
      rvalid1 <= rd_pend &  rd_id;
    end
  end

  assign rdata0 = ram_dout;
  assign rdata1 = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter. It includes a behavioural
// single-port RAM with a registered read.
// Expected grants and read data are queued as requests are issued.
module tb_ram_arbiter;

  localparam int WIDTH      = 8;
  localparam int ADDR_WIDTH = 10;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  req0, we0, gnt0, rvalid0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [WIDTH-1:0]      wdata0, rdata0;
  logic                  req1, we1, gnt1, rvalid1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [WIDTH-1:0]      wdata1, rdata1;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [WIDTH-1:0]      ram_din, ram_dout;

  ram_arbiter #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM with read-before-write and a registered read.
  logic [WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    int                    id;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      data;
  } exp_t;

  exp_t             gq[$];
  logic [WIDTH-1:0] rq0[$];
  logic [WIDTH-1:0] rq1[$];
  logic [WIDTH-1:0] shadow [0:(1<<ADDR_WIDTH)-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Queue the expected grant and, for reads, the expected data, in expected grant order.
  task automatic push(input int id, input bit we, input int addr, input int data, input bit want);
    exp_t e;
    e.id   = id;
    e.we   = we;
    e.addr = addr[ADDR_WIDTH-1:0];
    e.data = data[WIDTH-1:0];
    gq.push_back(e);
    if (we) shadow[addr] = data[WIDTH-1:0];
    else if (want) begin
      if (id == 0) rq0.push_back(shadow[addr]);
      else         rq1.push_back(shadow[addr]);
    end
  endtask

  task automatic start_req(input int port, input bit we, input int addr, input int data);
    if (port == 0) begin
      req0 = 1'b1; we0 = we; addr0 = addr[ADDR_WIDTH-1:0]; wdata0 = data[WIDTH-1:0];
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr[ADDR_WIDTH-1:0]; wdata1 = data[WIDTH-1:0];
    end
  endtask

  task automatic wait_gnt(input int port);
    int  n   = 0;
    bit  got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      got = (port == 0) ? gnt0 : gnt1;
      n++;
    end
    if (!got) chk("gnt_timeout", {31'b0, (port == 0) ? gnt0 : gnt1}, 32'd1);
    if (port == 0) req0 = 1'b0;
    else           req1 = 1'b0;
  endtask

  task automatic do_req(input int port, input bit we, input int addr, input int data);
    start_req(port, we, addr, data);
    wait_gnt(port);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  // Monitor: reset state, grant order, RAM command, rvalid timing and read data.
  logic rst_seen = 1'b1;
  logic rdx0 = 1'b0, rdx1 = 1'b0;
  always @(posedge clk) rst_seen <= rst;

  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      chk("reset_state", {9'b0, gnt0, gnt1, rvalid0, rvalid1, ram_we, ram_addr, ram_din}, 32'd0);
      rdx0 = 1'b0;
      rdx1 = 1'b0;
    end else begin
      chk("rvalid0", {31'b0, rvalid0}, {31'b0, rdx0});
      chk("rvalid1", {31'b0, rvalid1}, {31'b0, rdx1});
      if (rvalid0 && rq0.size() > 0) chk("rdata0", {24'b0, rdata0}, {24'b0, rq0.pop_front()});
      if (rvalid1 && rq1.size() > 0) chk("rdata1", {24'b0, rdata1}, {24'b0, rq1.pop_front()});
      if (gnt0 || gnt1) begin
        chk("gnt_both", {31'b0, gnt0 & gnt1}, 32'd0);
        if (gq.size() == 0) begin
          chk("gnt_unexpected", {30'b0, gnt1, gnt0}, 32'd0);
        end else begin
          e = gq.pop_front();
          chk("gnt_id", {31'b0, gnt1}, e.id);
          chk("ram_we", {31'b0, ram_we}, {31'b0, e.we});
          chk("ram_addr", {22'b0, ram_addr}, {22'b0, e.addr});
          chk("ram_din", {24'b0, ram_din}, {24'b0, e.data});
        end
      end else begin
        chk("idle_we", {31'b0, ram_we}, 32'd0);
      end
      rdx0 = gnt0 & ~ram_we;
      rdx1 = gnt1 & ~ram_we;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

    // Reset with both requests held, then requester 0 wins first.
    start_req(0, 1'b1, 16, 8'h11);
    start_req(1, 1'b1, 17, 8'h22);
    idle(2);
    push(0, 1'b1, 16, 8'h11, 1'b1);
    push(1, 1'b1, 17, 8'h22, 1'b1);
    rst = 1'b0;
    fork
      wait_gnt(0);
      wait_gnt(1);
    join
    idle(3);

    // Single write then read on port 0.
    do_reset();
    push(0, 1'b1, 2, 8'hAA, 1'b1);
    do_req(0, 1'b1, 2, 8'hAA);
    push(0, 1'b0, 2, 0, 1'b1);
    do_req(0, 1'b0, 2, 0);
    idle(3);

    // Continuous contention: grants alternate 0,1,0,1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b1, 4, 8'hBB, 1'b1);
      push(1, 1'b1, 7, 8'hCC, 1'b1);
    end
    fork
      begin repeat (4) do_req(0, 1'b1, 4, 8'hBB); end
      begin repeat (4) do_req(1, 1'b1, 7, 8'hCC); end
    join
    idle(2);
    push(0, 1'b0, 4, 0, 1'b1);
    do_req(0, 1'b0, 4, 0);
    push(1, 1'b0, 7, 0, 1'b1);
    do_req(1, 1'b0, 7, 0);
    idle(3);

    // Interleaved reads and writes with no bubble.
    do_reset();
    push(0, 1'b0, 4, 0, 1'b1);
    push(1, 1'b1, 4, 8'h3C, 1'b1);
    push(0, 1'b0, 7, 0, 1'b1);
    push(1, 1'b0, 4, 0, 1'b1);
    fork
      begin do_req(0, 1'b0, 4, 0); do_req(0, 1'b0, 7, 0); end
      begin do_req(1, 1'b1, 4, 8'h3C); do_req(1, 1'b0, 4, 0); end
    join
    idle(3);

    // Read-after-write across ports.
    do_reset();
    push(0, 1'b1, 9, 8'h5A, 1'b1);
    push(1, 1'b0, 9, 0, 1'b1);
    fork
      do_req(0, 1'b1, 9, 8'h5A);
      begin idle(1); do_req(1, 1'b0, 9, 0); end
    join
    idle(3);

    // Reset while the port 1 read grant is visible: the read is dropped.
    do_reset();
    push(1, 1'b0, 9, 0, 1'b0);
    start_req(1, 1'b0, 9, 0);
    wait_gnt(1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(4);

    chk("grants_left", gq.size(), 32'd0);
    chk("rdata0_left", rq0.size(), 32'd0);
    chk("rdata1_left", rq1.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
